fetch_arbiter: RTL
==================

Name: fetch_arbiter

Overview:
Round-robin arbiter that shares one program-memory read port among NUM_FETCHERS instruction fetchers (one per core). Each fetcher raises a read request with a PC address. The arbiter grants one requester at a time, runs a valid/ready read against program memory, and returns the instruction word to the winner through a 4-phase handshake. It sits between the per-core fetcher blocks and the program-memory controller.

Parameters:
NUM_FETCHERS, 4, number of requesting fetchers (2..8)
ADDR_WIDTH, 16, program-memory address width
DATA_WIDTH, 16, instruction word width
ID_WIDTH, 2, width of grant index; must equal clog2(NUM_FETCHERS)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_FETCHERS  per-fetcher read request
req_addr  input  NUM_FETCHERS*ADDR_WIDTH  packed PCs; fetcher i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
resp_valid  output  NUM_FETCHERS  per-fetcher response valid
resp_data  output  DATA_WIDTH  instruction word, meaningful only where resp_valid is set
mem_read_valid  output  1  read request to program memory
mem_read_address  output  ADDR_WIDTH  read address
mem_read_ready  input  1  memory has data on mem_read_data this cycle
mem_read_data  input  DATA_WIDTH  returned instruction
grant_id  output  ID_WIDTH  index of current or last winner
busy  output  1  high in WAIT_MEM or RESPOND

Behaviour:
- Clock and reset: one clock domain. Asynchronous active-low reset.
- All outputs are registered.
- Reset values: state=IDLE; resp_valid=0; resp_data=0; mem_read_valid=0; mem_read_address=0; grant_id=0; busy=0; rr_ptr=0.
- Reset asserted mid-transaction aborts it immediately. mem_read_valid drops asynchronously. No response is delivered.
- Round-robin: in IDLE, the winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_FETCHERS.
- FSM state IDLE:
  - No req_valid set: stay in IDLE.
  - Otherwise: latch winner into grant_id; latch req_addr[winner] into mem_read_address; set mem_read_valid=1 and busy=1; go to WAIT_MEM.
- FSM state WAIT_MEM:
  - Hold mem_read_valid and mem_read_address stable until mem_read_ready=1.
  - On mem_read_ready=1: capture mem_read_data into resp_data; set resp_valid[grant_id]=1; clear mem_read_valid; go to RESPOND.
  - mem_read_ready while mem_read_valid=0 is ignored in every state.
- FSM state RESPOND:
  - Hold resp_valid[grant_id] and resp_data while req_valid[grant_id]=1.
  - When req_valid[grant_id]=0: clear resp_valid; rr_ptr=(grant_id+1) mod NUM_FETCHERS; busy=0; go to IDLE.
- Latency: request seen in IDLE at cycle 0 gives mem_read_valid=1 at cycle 1. mem_read_ready at cycle k gives resp_valid at cycle k+1. Minimum request-to-response is 2 cycles.
- Requester rules:
  - Hold req_valid and req_addr stable until its resp_valid is seen, then drop req_valid.
  - Requests from non-winners may assert or deassert at any time. They are sampled only in IDLE.
- Winner drops req_valid during WAIT_MEM (protocol violation): the memory read still completes. RESPOND then sees req_valid low, so resp_valid pulses for exactly one cycle before IDLE.
- At most one resp_valid bit is high at any time. mem_read_valid is never high outside WAIT_MEM.
- A requester whose req_valid is still high in IDLE after completion competes normally. rr_ptr ensures every other pending requester is served before it again (no starvation; max wait is NUM_FETCHERS-1 transactions).
- req_addr changes from the winner after the IDLE latch do not affect mem_read_address.

Test Plan:
- Single request, mem_read_ready one cycle after issue.
  - Stimulus: reset; req_valid=4'b0001, addr0=16'h0003, memory returns 16'hDEAD.
  - Required: mem_read_valid at cycle 1 with address 0x0003; resp_valid=4'b0001 and resp_data=0xDEAD at cycle 3; held until req_valid[0] drops, then IDLE.
- All four requesters pending together, addresses 0x0..0x3.
  - Stimulus: each requester re-requests after its response; memory latency 2 cycles.
  - Required: grant order 0,1,2,3,0; responses 0xA5A5, 0x5A5A, 0x1234, 0xDEAD to the matching fetchers; never two resp_valid bits high.
- Back-to-back re-request vs. pending peer.
  - Stimulus: req_valid[2] re-raised immediately after its response while req_valid[3] is pending.
  - Required: fetcher 3 is granted before fetcher 2.
- Memory stall.
  - Stimulus: mem_read_ready held low for 10 cycles.
  - Required: mem_read_valid and address 0x000F stable throughout; resp_data=0x9999 on the cycle after ready.
- Reset mid-transaction.
  - Stimulus: rst_n low during WAIT_MEM.
  - Required: mem_read_valid=0, resp_valid=0, grant_id=0 immediately. After release, a new request from fetcher 1 is granted first (rr_ptr=0, only 1 requesting).
- Winner drops req_valid during WAIT_MEM.
  - Required: exactly one-cycle resp_valid pulse, then IDLE.

Source files
------------

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter sharing one program-memory read port among NUM_FETCHERS
// instruction fetchers; the winner's word is returned over a 4-phase handshake.
`timescale 1ns/1ps
module fetch_arbiter #(
    parameter int NUM_FETCHERS = 4,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int ID_WIDTH     = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_FETCHERS-1:0]            req_valid,
    input  logic [NUM_FETCHERS*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_FETCHERS-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]              resp_data,
    output logic                               mem_read_valid,
    output logic [ADDR_WIDTH-1:0]              mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_WIDTH-1:0]              mem_read_data,
    output logic [ID_WIDTH-1:0]                grant_id,
    output logic                               busy
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        RESPOND  = 2'd2
    } state_t;

    state_t                  state_r, state_s;
    logic [ID_WIDTH-1:0]     rr_ptr_r, rr_ptr_s;
    logic [ID_WIDTH-1:0]     grant_id_r, grant_id_s;
    logic [NUM_FETCHERS-1:0] resp_valid_r, resp_valid_s;
    logic [DATA_WIDTH-1:0]   resp_data_r, resp_data_s;
    logic                    mem_read_valid_r, mem_read_valid_s;
    logic [ADDR_WIDTH-1:0]   mem_read_address_r, mem_read_address_s;
    logic                    busy_r, busy_s;

    logic [ID_WIDTH-1:0]     winner_s;
    logic [ADDR_WIDTH-1:0]   win_addr_s;
    logic                    winner_found_s;
    logic [NUM_FETCHERS-1:0] grant_onehot_s;
    logic                    grant_req_s;

    assign winner_found_s = |req_valid;
    assign grant_onehot_s = {{(NUM_FETCHERS-1){1'b0}}, 1'b1} << grant_id_r;
    assign grant_req_s    = |(req_valid & grant_onehot_s);

    // Nearest requester at or after rr_ptr (with wrap) wins; its PC is muxed out
    always_comb begin
        int dist_s;
        int best_s;
        winner_s   = {ID_WIDTH{1'b0}};
        win_addr_s = {ADDR_WIDTH{1'b0}};
        best_s     = NUM_FETCHERS;
        dist_s     = 0;
        for (int j = 0; j < NUM_FETCHERS; j++) begin
            dist_s = j - int'(rr_ptr_r);
            if (dist_s < 0) begin
                dist_s = dist_s + NUM_FETCHERS;
            end else begin
                dist_s = dist_s;
            end
            if (req_valid[j] && (dist_s < best_s)) begin
                best_s     = dist_s;
                winner_s   = ID_WIDTH'(j);
                win_addr_s = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            end else begin
                best_s = best_s;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_s            = state_r;
        rr_ptr_s           = rr_ptr_r;
        grant_id_s         = grant_id_r;
        resp_valid_s       = resp_valid_r;
        resp_data_s        = resp_data_r;
        mem_read_valid_s   = mem_read_valid_r;
        mem_read_address_s = mem_read_address_r;
        busy_s             = busy_r;
        case (state_r)
            IDLE: begin
                if (winner_found_s) begin
                    grant_id_s         = winner_s;
                    mem_read_address_s = win_addr_s;
                    mem_read_valid_s   = 1'b1;
                    busy_s             = 1'b1;
                    state_s            = WAIT_MEM;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_MEM: begin
                if (mem_read_ready) begin
                    resp_data_s      = mem_read_data;
                    resp_valid_s     = grant_onehot_s;
                    mem_read_valid_s = 1'b0;
                    state_s          = RESPOND;
                end else begin
                    state_s = WAIT_MEM;
                end
            end
            RESPOND: begin
                // Release once the winner acknowledges by dropping its request
                if (!grant_req_s) begin
                    resp_valid_s = {NUM_FETCHERS{1'b0}};
                    busy_s       = 1'b0;
                    state_s      = IDLE;
                    if (grant_id_r == ID_WIDTH'(NUM_FETCHERS-1)) begin
                        rr_ptr_s = {ID_WIDTH{1'b0}};
                    end else begin
                        rr_ptr_s = grant_id_r + ID_WIDTH'(1'b1);
                    end
                end else begin
                    state_s = RESPOND;
                end
            end
            default: begin
                state_s          = IDLE;
                resp_valid_s     = {NUM_FETCHERS{1'b0}};
                mem_read_valid_s = 1'b0;
                busy_s           = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= IDLE;
            rr_ptr_r           <= {ID_WIDTH{1'b0}};
            grant_id_r         <= {ID_WIDTH{1'b0}};
            resp_valid_r       <= {NUM_FETCHERS{1'b0}};
            resp_data_r        <= {DATA_WIDTH{1'b0}};
            mem_read_valid_r   <= 1'b0;
            mem_read_address_r <= {ADDR_WIDTH{1'b0}};
            busy_r             <= 1'b0;
        end else begin
            state_r            <= state_s;
            rr_ptr_r           <= rr_ptr_s;
            grant_id_r         <= grant_id_s;
            resp_valid_r       <= resp_valid_s;
            resp_data_r        <= resp_data_s;
            mem_read_valid_r   <= mem_read_valid_s;
            mem_read_address_r <= mem_read_address_s;
            busy_r             <= busy_s;
        end
    end

    assign resp_valid       = resp_valid_r;
    assign resp_data        = resp_data_r;
    assign mem_read_valid   = mem_read_valid_r;
    assign mem_read_address = mem_read_address_r;
    assign grant_id         = grant_id_r;
    assign busy             = busy_r;

endmodule
